// File: rtl/alu_rhs_func_decoder.sv
// rtl/alu_rhs_func_decoder.sv - recovers the ALU RHS AC3..AC0 function code from observed result triples
//
// Watches (LHS, RHS, Logic) triples from the RHS configurable-logic stage.
// Each bit position selects a row {RHS[i], LHS[i]}, and the Logic bit is
// that row's function output. The rows are accumulated until the code is
// fully known, a contradiction is seen, or SAMPLE_LIMIT samples are taken.
//
// Ports:
//   AluClock     - clock, rising edge
//   Reset        - asynchronous active-high reset
//   Start        - begin a capture (acted on only in IDLE)
//   SampleValid  - triple on LHS/RHS/Logic is valid
//   SampleReady  - block accepts triples (COLLECT only)
//   LHS, RHS     - operands of the sampled operation
//   Logic        - logic result for that LHS/RHS
//   Busy         - capture in progress
//   Done         - one-cycle completion pulse
//   FuncCode     - recovered code, bit n = AC n (0 for unknown rows)
//   CodeKnown    - bit n set once row n has been observed
//   Conflict     - an inconsistent sample was seen in this capture
//   SampleCount  - samples accepted in this capture
module alu_rhs_func_decoder #(
    parameter int SAMPLE_LIMIT = 16
) (
    input  logic                              AluClock,
    input  logic                              Reset,
    input  logic                              Start,
    input  logic                              SampleValid,
    output logic                              SampleReady,
    input  logic [7:0]                        LHS,
    input  logic [7:0]                        RHS,
    input  logic [7:0]                        Logic,
    output logic                              Busy,
    output logic                              Done,
    output logic [3:0]                        FuncCode,
    output logic [3:0]                        CodeKnown,
    output logic                              Conflict,
    output logic [$clog2(SAMPLE_LIMIT+1)-1:0] SampleCount
);

    localparam int CW = $clog2(SAMPLE_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t state, state_next;

    logic [3:0]    seen1, seen0;
    logic          conflict_hit;
    logic [3:0]    known_next;
    logic [3:0]    code_next;
    logic          conflict_next;
    logic [CW-1:0] count_next;
    logic          accept;
    logic          finish;

    // Per-sample row observations and the post-update capture state.
    always_comb begin
        seen1 = '0;
        seen0 = '0;
        for (int i = 0; i < 8; i++) begin
            if (Logic[i]) seen1[{RHS[i], LHS[i]}] = 1'b1;
            else          seen0[{RHS[i], LHS[i]}] = 1'b1;
        end
        // Contradiction either within the sample or against an earlier sample.
        conflict_hit  = |(seen1 & seen0)
                      | |(CodeKnown & seen1 & ~FuncCode)
                      | |(CodeKnown & seen0 &  FuncCode);
        known_next    = CodeKnown | seen1 | seen0;
        // Observed rows take the new value; a row seen both ways resolves to 1.
        code_next     = (FuncCode & ~(seen1 | seen0)) | seen1;
        conflict_next = Conflict | conflict_hit;
        count_next    = SampleCount + CW'(1);
        finish        = (known_next == 4'b1111) || conflict_next
                      || (count_next == CW'(SAMPLE_LIMIT));
    end

    assign accept = SampleValid && (state == COLLECT);

    always_ff @(posedge AluClock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        SampleReady = 1'b0;
        Busy        = 1'b0;
        Done        = 1'b0;
        case (state)
            IDLE: begin
                if (Start) state_next = COLLECT;
            end
            COLLECT: begin
                SampleReady = 1'b1;
                Busy        = 1'b1;
                if (accept && finish) state_next = DONE;
            end
            DONE: begin
                Done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge AluClock or posedge Reset) begin
        if (Reset) begin
            FuncCode    <= '0;
            CodeKnown   <= '0;
            Conflict    <= 1'b0;
            SampleCount <= '0;
        end else if (state == IDLE && Start) begin
            FuncCode    <= '0;
            CodeKnown   <= '0;
            Conflict    <= 1'b0;
            SampleCount <= '0;
        end else if (accept) begin
            FuncCode    <= code_next;
            CodeKnown   <= known_next;
            Conflict    <= conflict_next;
            SampleCount <= count_next;
        end
    end

endmodule

// File: tb/tb_alu_rhs_func_decoder.sv
// tb/tb_alu_rhs_func_decoder.sv - self-checking bench for alu_rhs_func_decoder
module tb_alu_rhs_func_decoder;

    logic       AluClock = 1'b0;
    logic       Reset = 1'b1;
    logic       Start = 1'b0;
    logic       SampleValid = 1'b0;
    logic       SampleReady;
    logic [7:0] LHS = '0;
    logic [7:0] RHS = '0;
    logic [7:0] Logic = '0;
    logic       Busy;
    logic       Done;
    logic [3:0] FuncCode;
    logic [3:0] CodeKnown;
    logic       Conflict;
    logic [4:0] SampleCount;

    int n_checks = 0;
    int n_fail   = 0;

    alu_rhs_func_decoder #(.SAMPLE_LIMIT(16)) dut (
        .AluClock    (AluClock),
        .Reset       (Reset),
        .Start       (Start),
        .SampleValid (SampleValid),
        .SampleReady (SampleReady),
        .LHS         (LHS),
        .RHS         (RHS),
        .Logic       (Logic),
        .Busy        (Busy),
        .Done        (Done),
        .FuncCode    (FuncCode),
        .CodeKnown   (CodeKnown),
        .Conflict    (Conflict),
        .SampleCount (SampleCount)
    );

    always #5 AluClock = ~AluClock;

    typedef struct {
        logic       start;
        logic [7:0] lhs;
        logic [7:0] rhs;
        logic [7:0] lg;
        logic [3:0] e_func;
        logic [3:0] e_known;
        logic       e_conf;
        logic [4:0] e_cnt;
        logic       e_done;
    } vec_t;

    vec_t tbl[40];
    int   n_vec = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic st, input logic [7:0] l, input logic [7:0] r, input logic [7:0] g,
                       input logic [3:0] f, input logic [3:0] k, input logic c,
                       input logic [4:0] n, input logic d);
        tbl[n_vec].start   = st;
        tbl[n_vec].lhs     = l;
        tbl[n_vec].rhs     = r;
        tbl[n_vec].lg      = g;
        tbl[n_vec].e_func  = f;
        tbl[n_vec].e_known = k;
        tbl[n_vec].e_conf  = c;
        tbl[n_vec].e_cnt   = n;
        tbl[n_vec].e_done  = d;
        n_vec++;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ready"}, SampleReady, 0);
        chk({tag, "_busy"},  Busy, 0);
        chk({tag, "_done"},  Done, 0);
        chk({tag, "_func"},  FuncCode, 0);
        chk({tag, "_known"}, CodeKnown, 0);
        chk({tag, "_conf"},  Conflict, 0);
        chk({tag, "_cnt"},   SampleCount, 0);
    endtask

    initial begin
        // AND in one sample
        add(1, 8'h0F, 8'h33, 8'h03, 4'b1000, 4'b1111, 0, 1, 1);
        // XOR over four back-to-back samples
        add(1, 8'hFF, 8'h00, 8'hFF, 4'b0010, 4'b0010, 0, 1, 0);
        add(0, 8'h00, 8'h00, 8'h00, 4'b0010, 4'b0011, 0, 2, 0);
        add(0, 8'hAA, 8'hAA, 8'h00, 4'b0010, 4'b1011, 0, 3, 0);
        add(0, 8'h00, 8'hFF, 8'hFF, 4'b0110, 4'b1111, 0, 4, 1);
        // intra-sample conflict: row 0 seen as both 0 and 1, 1 wins
        add(1, 8'h00, 8'h00, 8'h01, 4'b0001, 4'b0001, 1, 1, 1);
        // inter-sample conflict: row 3 flips, last writer wins
        add(1, 8'hFF, 8'hFF, 8'hFF, 4'b1000, 4'b1000, 0, 1, 0);
        add(0, 8'hFF, 8'hFF, 8'h00, 4'b0000, 4'b1000, 1, 2, 1);
        // timeout after SAMPLE_LIMIT samples
        for (int k = 0; k < 16; k++)
            add(k == 0, 8'h00, 8'h00, 8'h00, 4'b0000, 4'b0001, 0, 5'(k + 1), k == 15);

        // reset state
        repeat (3) @(posedge AluClock);
        @(negedge AluClock);
        Reset = 1'b0;
        #1 chk_zero("reset");

        // valid without Start is ignored
        SampleValid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge AluClock);
            #1;
            chk("idle_ready", SampleReady, 0);
            chk("idle_cnt", SampleCount, 0);
            chk("idle_busy", Busy, 0);
        end
        SampleValid = 1'b0;

        for (int v = 0; v < n_vec; v++) begin
            @(negedge AluClock);
            if (tbl[v].start) begin
                SampleValid = 1'b0;
                Start = 1'b1;
                @(negedge AluClock);
                Start = 1'b0;
                chk($sformatf("v%0d_start_busy", v), Busy, 1);
                chk($sformatf("v%0d_start_ready", v), SampleReady, 1);
                chk($sformatf("v%0d_start_known", v), CodeKnown, 0);
                chk($sformatf("v%0d_start_cnt", v), SampleCount, 0);
            end
            SampleValid = 1'b1;
            LHS   = tbl[v].lhs;
            RHS   = tbl[v].rhs;
            Logic = tbl[v].lg;
            @(posedge AluClock);
            #1;
            chk($sformatf("v%0d_func", v),  FuncCode, tbl[v].e_func);
            chk($sformatf("v%0d_known", v), CodeKnown, tbl[v].e_known);
            chk($sformatf("v%0d_conf", v),  Conflict, tbl[v].e_conf);
            chk($sformatf("v%0d_cnt", v),   SampleCount, tbl[v].e_cnt);
            chk($sformatf("v%0d_done", v),  Done, tbl[v].e_done);
            chk($sformatf("v%0d_busy", v),  Busy, !tbl[v].e_done);
            if (tbl[v].e_done) begin
                @(negedge AluClock);
                SampleValid = 1'b0;
                @(posedge AluClock);
                #1;
                chk($sformatf("v%0d_post_done", v), Done, 0);
                chk($sformatf("v%0d_post_busy", v), Busy, 0);
                chk($sformatf("v%0d_post_ready", v), SampleReady, 0);
                chk($sformatf("v%0d_hold_known", v), CodeKnown, tbl[v].e_known);
                chk($sformatf("v%0d_hold_cnt", v), SampleCount, tbl[v].e_cnt);
            end
        end

        // mid-cycle reset clears held results immediately
        @(posedge AluClock);
        #2 Reset = 1'b1;
        #1 chk_zero("midreset");
        @(negedge AluClock);
        Reset = 1'b0;

        // abort a capture with reset after two samples
        Start = 1'b1;
        @(negedge AluClock);
        Start = 1'b0;
        SampleValid = 1'b1;
        LHS = 8'h00; RHS = 8'h00; Logic = 8'h00;
        repeat (2) @(posedge AluClock);
        #1;
        chk("abort_cnt2", SampleCount, 2);
        chk("abort_busy", Busy, 1);
        #1 Reset = 1'b1;
        #1 chk_zero("abort");
        SampleValid = 1'b0;
        @(negedge AluClock);
        Reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge AluClock);
            #1;
            chk("abort_no_done", Done, 0);
            chk("abort_idle", Busy, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
